gcd_sched: RTL

- Round-robin scheduler that shares one GCD engine among N requesters.
- The engine takes a packed operand pair through a valid/ready input, holds a single operation, and pulses out_valid for one cycle with the result; it has no output backpressure.
- gcd_sched accepts requests, issues them to the engine one at a time, and parks each result in a per-requester response slot until that requester consumes it.
- Sits between the client fabric and the GCD engine and guards the engine against operand patterns that never terminate.

---
 rtl/gcd_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin scheduler sharing one GCD engine among N requesters.
//
// Requests are granted one at a time, issued to the engine over a valid/ready
// operand bus, and each result is parked in a per-requester response slot until
// that requester consumes it. Requests with a == 0 are answered locally with b,
// because the engine never terminates on a == 0, b != 0.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   req_valid/ready    per-requester request handshake; req_ready is one-hot
//   req_data           requester i at [i*2W +: 2W], a in low W, b in high W
//   resp_valid/ready   per-requester result slot full / consume strobe
//   resp_data          slot i at [i*W +: W]
//   gcd_in_*           engine operand bus {b, a} with valid/ready
//   gcd_out_*          engine result pulse (no backpressure)
//   busy               high while an operation is being issued or awaited
//   owner              requester index of the current or last operation
//   last_lat           latency of the last operation, saturating at 0xFFFF
module gcd_sched #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*2*W-1:0]     req_data,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         resp_valid,
  output logic [N*W-1:0]       resp_data,
  input  logic [N-1:0]         resp_ready,
  output logic                 gcd_in_valid,
  output logic [2*W-1:0]       gcd_in_data,
  input  logic                 gcd_in_ready,
  input  logic                 gcd_out_valid,
  input  logic [W-1:0]         gcd_out_data,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic [15:0]          last_lat
);

  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic [15:0]         last_lat_q;
  logic [15:0]         lat_cnt_q;
  logic                in_valid_q;
  logic [2*W-1:0]      in_data_q;
  logic [N-1:0]        resp_valid_q, resp_valid_d;
  logic [N*W-1:0]      resp_data_q, resp_data_d;

  logic [N-1:0]        elig;
  logic                gnt_found;
  logic [IdxW-1:0]     gnt_idx, scan_idx;
  logic [W-1:0]        gnt_a, gnt_b;
  logic                wr_en;
  logic [IdxW-1:0]     wr_idx;
  logic [W-1:0]        wr_data;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
    if (32'(i) == N - 1) return '0;
    return i + 1'b1;
  endfunction

  // A slot being consumed this cycle still counts as full, so eligibility
  // looks at the registered slot state only.
  always_comb begin
    elig      = req_valid & ~resp_valid_q;
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_found && elig[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  assign gnt_a = req_data[32'(gnt_idx) * 2 * W +: W];
  assign gnt_b = req_data[32'(gnt_idx) * 2 * W + W +: W];

  // Reset gates the strobe so it reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !reset && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Slot writes: local bypass result in IDLE, engine result in WAIT.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = owner_q;
    wr_data = gcd_out_data;
    if (state_q == StIdle && gnt_found && gnt_a == '0) begin
      wr_en   = 1'b1;
      wr_idx  = gnt_idx;
      wr_data = gnt_b;
    end else if (state_q == StWait && gcd_out_valid) begin
      wr_en   = 1'b1;
      wr_idx  = owner_q;
      wr_data = gcd_out_data;
    end
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_data_d  = resp_data_q;
    if (wr_en) begin
      resp_valid_d[wr_idx]               = 1'b1;
      resp_data_d[32'(wr_idx) * W +: W]  = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      last_lat_q   <= '0;
      lat_cnt_q    <= '0;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            owner_q   <= gnt_idx;
            lat_cnt_q <= '0;
            in_data_q <= {gnt_b, gnt_a};
            if (gnt_a == '0) begin
              last_lat_q <= 16'd1;
              rr_ptr_q   <= wrap_inc(gnt_idx);
            end else begin
              in_valid_q <= 1'b1;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          if (gcd_in_ready) begin
            in_valid_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (lat_cnt_q != 16'hFFFF) lat_cnt_q <= lat_cnt_q + 16'd1;
          if (gcd_out_valid) begin
            last_lat_q <= (lat_cnt_q == 16'hFFFF) ? 16'hFFFF : lat_cnt_q + 16'd1;
            rr_ptr_q   <= wrap_inc(owner_q);
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign gcd_in_valid = in_valid_q;
  assign gcd_in_data  = in_data_q;
  assign busy         = (state_q != StIdle);
  assign owner        = owner_q;
  assign last_lat     = last_lat_q;

endmodule
